microcode_sequencer: RTL and testbench
======================================

# microcode_sequencer

Parametrised microcode control unit for the nibble CPU. It replaces the fixed opcode/flag/phase decode ROM with a writable microcode table, an internal phase counter with per-word early termination, and optional flag latching. Each enabled cycle it issues one registered control word to the datapath. The block sits between the instruction register/flag register and the datapath control lines.

## Interface
- OP_W, default 4: opcode width.
- FLAG_W, default 2: condition-flag width (C, Z).
- PH_W, default 2: phase counter width; at most 2**PH_W phases per instruction.
- CW, default 13: control-word width.
- FLAG_LATCH, default 1: 1 = flags sampled once at phase 0 and held for the instruction; 0 = flags read live every phase.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  step enable; one microstep per cycle with en=1.
- opcode  in  OP_W  instruction opcode; sampled only on the phase-0 step.
- flags  in  FLAG_W  condition flags.
- wr_en  in  1  microcode table write strobe.
- wr_addr  in  OP_W+FLAG_W+PH_W  table address {opcode, flags, phase}.
- wr_data  in  CW+1  microword; bit CW = END, bits CW-1:0 = control.
- ctrl  out  CW  registered control word.
- phase  out  PH_W  phase of the word currently on ctrl.
- last  out  1  registered; 1 when the word on ctrl ends its instruction.
- fetch  out  1  combinational; 1 when the next step is phase 0 and opcode will be sampled.

## Operation
- Internal state: phase_r (next phase to issue), op_r, flag_r.
- Effective opcode: opcode when phase_r==0, else op_r.
- Effective flags: if FLAG_LATCH=1, flags when phase_r==0, else flag_r. If FLAG_LATCH=0, always flags.
- Read address = {eff_op, eff_flags, phase_r}. word = table[addr].
- On en=1:
  - ctrl <= word[CW-1:0].
  - phase <= phase_r.
  - last <= word[CW] | (phase_r == all-ones).
  - When phase_r==0: op_r <= opcode and flag_r <= flags.
  - phase_r <= 0 if word[CW] or phase_r is all-ones (wrap); otherwise phase_r+1.
- On en=0: all registers hold. Table writes still occur.
- Write: when wr_en=1, table[wr_addr] <= wr_data at the clock edge. A same-cycle read of the same address returns the old contents. Writes are independent of en and reset.
- Reset: phase_r=0, op_r=0, flag_r=0, ctrl=0, phase=0, last=0. fetch=1 after reset. Table contents are not cleared and are undefined until written.
- Reset asserted mid-instruction aborts it: the next enabled step is phase 0 with a fresh opcode. Reset wins over en.

## Timing
- Latency: opcode/flags/phase_r to ctrl is 1 cycle (combinational table read, registered output).
- An instruction of N words (END set on word N-1, N ≤ 2**PH_W) occupies exactly N enabled cycles. Back-to-back instructions have no bubble.
- fetch tracks phase_r combinationally. The upstream must present a valid opcode whenever fetch=1 and en=1.
- A stall (en=0) inserted mid-instruction extends it without altering the phase sequence or the latched flags.
- A table write to an address that is read in a later cycle is visible to that read (1-cycle write-to-read).

## Structure
- Shared package `microcode_pkg`:
  - default parameter constants;
  - address-field positions (OP, FLAG, PHASE);
  - END bit index;
  - the named control-word bit positions of the 13-bit nibble-CPU word.
- Sub-module `microcode_ram`: 2**(OP_W+FLAG_W+PH_W) × (CW+1), one synchronous write port, one combinational read port, no reset.
- Top: phase counter, opcode/flag latches, output registers, and fetch logic.

## Test plan
- **Reset:** reset=1 for 2 cycles mid-run -> ctrl=0, phase=0, last=0, fetch=1. With en=1, the first step issues phase 0 of the new opcode.
- **Two-phase instruction:** write table[{4'h2,2'b00,2'd0}]=14'h0010 and table[{4'h2,2'b00,2'd1}]=14'h2042 (END). Step with opcode=2, flags=0 -> ctrl=0x0010 with phase=0, last=0; then ctrl=0x0042 with phase=1, last=1; then fetch=1.
- **Full-length wrap:** 4 words with no END -> phases 0,1,2,3 issued. last=1 on phase 3 and phase_r wraps to 0.
- **Flag latch:** FLAG_LATCH=1, flags=01 at phase 0 then 10 at phase 1 -> phase 1 reads the {op,01,1} entry. With FLAG_LATCH=0 the same stimulus reads the {op,10,1} entry.
- **Stall:** en=0 for 3 cycles after phase 0 -> ctrl/phase/last hold. Phase 1 issues on the next en, and opcode changes during the stall are ignored.
- **Write collision:** rewrite the phase-1 entry in the same cycle it is read -> old word issued. On the next pass of that instruction -> new word issued.

Source files
------------

// File: rtl/microcode_pkg.sv
// rtl/microcode_pkg.sv - shared constants for the nibble-CPU microcode sequencer
package microcode_pkg;

    localparam int OP_W_DEF       = 4;
    localparam int FLAG_W_DEF     = 2;
    localparam int PH_W_DEF       = 2;
    localparam int CW_DEF         = 13;
    localparam bit FLAG_LATCH_DEF = 1'b1;

    // Table address is {opcode, flags, phase}, phase in the low bits.
    localparam int ADDR_PHASE_LSB = 0;
    localparam int ADDR_FLAG_LSB  = PH_W_DEF;
    localparam int ADDR_OP_LSB    = PH_W_DEF + FLAG_W_DEF;
    localparam int ADDR_W_DEF     = OP_W_DEF + FLAG_W_DEF + PH_W_DEF;

    localparam int END_BIT = CW_DEF;

    typedef logic [CW_DEF:0]     uword_t;
    typedef logic [ADDR_W_DEF-1:0] uaddr_t;

    localparam int CTL_PC_INC    = 0;
    localparam int CTL_PC_LOAD   = 1;
    localparam int CTL_MAR_LOAD  = 2;
    localparam int CTL_RAM_RD    = 3;
    localparam int CTL_RAM_WR    = 4;
    localparam int CTL_IR_LOAD   = 5;
    localparam int CTL_A_LOAD    = 6;
    localparam int CTL_B_LOAD    = 7;
    localparam int CTL_ALU_OUT   = 8;
    localparam int CTL_ALU_SUB   = 9;
    localparam int CTL_FLAG_LOAD = 10;
    localparam int CTL_OUT_LOAD  = 11;
    localparam int CTL_HALT      = 12;

endpackage

// File: rtl/microcode_ram.sv
// rtl/microcode_ram.sv - writable microcode table, sync write, async read, no reset
module microcode_ram
    import microcode_pkg::*;
#(
    parameter int AW = ADDR_W_DEF,
    parameter int DW = CW_DEF + 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read in the write cycle sees the pre-edge contents.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - phase counter, op/flag latches and registered control word
module microcode_sequencer
    import microcode_pkg::*;
#(
    parameter int OP_W       = OP_W_DEF,
    parameter int FLAG_W     = FLAG_W_DEF,
    parameter int PH_W       = PH_W_DEF,
    parameter int CW         = CW_DEF,
    parameter bit FLAG_LATCH = FLAG_LATCH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [OP_W-1:0]          opcode,
    input  logic [FLAG_W-1:0]        flags,
    input  logic                     wr_en,
    input  logic [OP_W+FLAG_W+PH_W-1:0] wr_addr,
    input  logic [CW:0]              wr_data,
    output logic [CW-1:0]            ctrl,
    output logic [PH_W-1:0]          phase,
    output logic                     last,
    output logic                     fetch
);

    localparam int AW = OP_W + FLAG_W + PH_W;

    logic [PH_W-1:0]   phase_r;
    logic [OP_W-1:0]   op_r;
    logic [FLAG_W-1:0] flag_r;
    logic [OP_W-1:0]   eff_op;
    logic [FLAG_W-1:0] eff_flags;
    logic [AW-1:0]     rd_addr;
    logic [CW:0]       word;
    logic              phase_zero;
    logic              ends;

    assign phase_zero = (phase_r == '0);
    assign eff_op     = phase_zero ? opcode : op_r;
    assign eff_flags  = (FLAG_LATCH && !phase_zero) ? flag_r : flags;
    assign rd_addr    = {eff_op, eff_flags, phase_r};
    // An instruction ends on an END word or when the phase counter runs out.
    assign ends       = word[CW] | (phase_r == '1);
    assign fetch      = phase_zero;

    microcode_ram #(
        .AW (AW),
        .DW (CW + 1)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= '0;
            op_r    <= '0;
            flag_r  <= '0;
            ctrl    <= '0;
            phase   <= '0;
            last    <= 1'b0;
        end else if (en) begin
            ctrl  <= word[CW-1:0];
            phase <= phase_r;
            last  <= ends;
            if (phase_zero) begin
                op_r   <= opcode;
                flag_r <= flags;
            end
            phase_r <= ends ? '0 : phase_r + 1'b1;
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - randomized bench with instruction-level reference model
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        reset, en, wr_en;
    logic [3:0]  opcode;
    logic [1:0]  flags;
    logic [7:0]  wr_addr;
    logic [13:0] wr_data;

    logic [12:0] ctrl_l, ctrl_v;
    logic [1:0]  phase_l, phase_v;
    logic        last_l, last_v, fetch_l, fetch_v;

    int vectors = 0;
    int miscompares = 0;
    bit chk = 1'b0;

    always #5 clk = ~clk;

    microcode_sequencer #(.FLAG_LATCH(1'b1)) u_dut (
        .clk(clk), .reset(reset), .en(en), .opcode(opcode), .flags(flags),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ctrl(ctrl_l), .phase(phase_l), .last(last_l), .fetch(fetch_l)
    );

    microcode_sequencer #(.FLAG_LATCH(1'b0)) u_live (
        .clk(clk), .reset(reset), .en(en), .opcode(opcode), .flags(flags),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ctrl(ctrl_v), .phase(phase_v), .last(last_v), .fetch(fetch_v)
    );

    // Reference: table image plus, per instance, the position within the
    // current instruction and the opcode/flags captured at its start.
    logic [13:0] tbl [256];
    int          m_pos  [2];
    logic [3:0]  m_op   [2];
    logic [1:0]  m_fl   [2];
    logic [12:0] e_ctrl [2];
    int          e_ph   [2];
    bit          e_last [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_pos[i] = 0; m_op[i] = 0; m_fl[i] = 0;
                e_ctrl[i] = 0; e_ph[i] = 0; e_last[i] = 0;
            end else if (en) begin
                logic [3:0]  op;
                logic [1:0]  f;
                logic [1:0]  p;
                logic [13:0] w;
                p  = m_pos[i][1:0];
                op = (m_pos[i] == 0) ? opcode : m_op[i];
                f  = (i == 1 || m_pos[i] == 0) ? flags : m_fl[i];
                w  = tbl[{op, f, p}];
                e_ctrl[i] = w[12:0];
                e_ph[i]   = m_pos[i];
                e_last[i] = w[13] || (m_pos[i] == 3);
                if (m_pos[i] == 0) begin
                    m_op[i] = opcode;
                    m_fl[i] = flags;
                end
                m_pos[i] = e_last[i] ? 0 : m_pos[i] + 1;
            end
        end
        if (wr_en) tbl[wr_addr] = wr_data;
    end

    always @(negedge clk) begin
        if (chk) begin
            check("latch.ctrl",  32'(ctrl_l),  32'(e_ctrl[0]));
            check("latch.phase", 32'(phase_l), 32'(e_ph[0]));
            check("latch.last",  32'(last_l),  32'(e_last[0]));
            check("latch.fetch", 32'(fetch_l), 32'(m_pos[0] == 0));
            check("live.ctrl",   32'(ctrl_v),  32'(e_ctrl[1]));
            check("live.phase",  32'(phase_v), 32'(e_ph[1]));
            check("live.last",   32'(last_v),  32'(e_last[1]));
            check("live.fetch",  32'(fetch_v), 32'(m_pos[1] == 0));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [13:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic random_run(input int n);
        for (int k = 0; k < n; k++) begin
            reset   = ($urandom % 64) == 0;
            en      = ($urandom % 4) != 0;
            opcode  = 4'($urandom);
            flags   = 2'($urandom);
            wr_en   = ($urandom % 8) == 0;
            wr_addr = 8'($urandom);
            wr_data = 14'($urandom);
            tick;
        end
        reset = 1'b0; en = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; opcode = 0; flags = 0;
        wr_en = 1'b0; wr_addr = 0; wr_data = 0;
        tick;
        chk = 1'b1;
        for (int a = 0; a < 256; a++) begin
            write_word(a[7:0], 14'($urandom));
        end
        reset = 1'b0;
        random_run(1500);

        // Reset mid-run with en held high; table writes proceed meanwhile.
        reset = 1'b1; en = 1'b1;
        write_word({4'h2, 2'b00, 2'd0}, 14'h0010);
        write_word({4'h2, 2'b00, 2'd1}, 14'h2042);
        check("rst.ctrl",  32'(ctrl_l),  32'h0);
        check("rst.phase", 32'(phase_l), 32'h0);
        check("rst.last",  32'(last_l),  32'h0);
        check("rst.fetch", 32'(fetch_l), 32'h1);

        reset = 1'b0; en = 1'b1; opcode = 4'h2; flags = 2'b00;
        tick;
        check("two.p0.ctrl",  32'(ctrl_l),  32'h0010);
        check("two.p0.phase", 32'(phase_l), 32'h0);
        check("two.p0.last",  32'(last_l),  32'h0);
        check("two.p0.fetch", 32'(fetch_l), 32'h0);
        opcode = 4'h9;
        tick;
        check("two.p1.ctrl",  32'(ctrl_l),  32'h0042);
        check("two.p1.phase", 32'(phase_l), 32'h1);
        check("two.p1.last",  32'(last_l),  32'h1);
        check("two.fetch",    32'(fetch_l), 32'h1);
        en = 1'b0;

        for (int k = 0; k < 4; k++) write_word({4'h5, 2'b00, 2'(k)}, 14'h0100 + 14'(k));
        en = 1'b1; opcode = 4'h5; flags = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick;
            check("wrap.ctrl",  32'(ctrl_l),  32'h100 + 32'(k));
            check("wrap.phase", 32'(phase_l), 32'(k));
            check("wrap.last",  32'(last_l),  32'(k == 3));
            opcode = 4'($urandom);
        end
        check("wrap.fetch", 32'(fetch_l), 32'h1);
        en = 1'b0;

        write_word({4'h6, 2'b01, 2'd0}, 14'h0001);
        write_word({4'h6, 2'b01, 2'd1}, 14'h2011);
        write_word({4'h6, 2'b10, 2'd1}, 14'h2022);
        en = 1'b1; opcode = 4'h6; flags = 2'b01;
        tick;
        check("flag.p0.latch", 32'(ctrl_l), 32'h0001);
        check("flag.p0.live",  32'(ctrl_v), 32'h0001);
        flags = 2'b10;
        tick;
        check("flag.p1.latch", 32'(ctrl_l), 32'h0011);
        check("flag.p1.live",  32'(ctrl_v), 32'h0022);
        check("flag.p1.last",  32'(last_l), 32'h1);
        en = 1'b0; flags = 2'b00;

        write_word({4'h7, 2'b00, 2'd0}, 14'h00a0);
        write_word({4'h7, 2'b00, 2'd1}, 14'h20b0);
        en = 1'b1; opcode = 4'h7;
        tick;
        check("stall.p0.ctrl", 32'(ctrl_l), 32'h00a0);
        en = 1'b0; opcode = 4'h5; flags = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("stall.hold.ctrl",  32'(ctrl_l),  32'h00a0);
            check("stall.hold.phase", 32'(phase_l), 32'h0);
            check("stall.hold.last",  32'(last_l),  32'h0);
        end
        en = 1'b1; flags = 2'b00;
        tick;
        check("stall.p1.ctrl",  32'(ctrl_l),  32'h00b0);
        check("stall.p1.phase", 32'(phase_l), 32'h1);
        check("stall.p1.last",  32'(last_l),  32'h1);
        en = 1'b0;

        write_word({4'h8, 2'b00, 2'd0}, 14'h00c1);
        write_word({4'h8, 2'b00, 2'd1}, 14'h2111);
        en = 1'b1; opcode = 4'h8;
        tick;
        check("coll.p0.ctrl", 32'(ctrl_l), 32'h00c1);
        write_word({4'h8, 2'b00, 2'd1}, 14'h2222);
        check("coll.old.ctrl", 32'(ctrl_l), 32'h0111);
        check("coll.old.last", 32'(last_l), 32'h1);
        tick;
        check("coll.again.p0", 32'(ctrl_l), 32'h00c1);
        tick;
        check("coll.new.ctrl", 32'(ctrl_l), 32'h0222);
        en = 1'b0;

        random_run(1500);
        tick;
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
